// File: rtl/imem_pkg.sv
// Shared constants for the Hack instruction-memory arbiter: state encoding,
// word width and default geometry.
package imem_pkg;

  localparam logic ST_LOAD         = 1'b0;
  localparam logic ST_RUN          = 1'b1;
  localparam int   IMEM_DW         = 16;
  localparam int   IMEM_AW_DEF     = 8;
  localparam int   STARVE_MAX_DEF  = 15;

  typedef enum logic {
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN
  } imem_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// CPU fetch, loader write and RAM port bundle of the instruction-memory arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface imem_arbiter_if #(
  parameter int AW = imem_pkg::IMEM_AW_DEF
);
  import imem_pkg::*;

  logic               cpu_req;
  logic [IMEM_DW-1:0] cpu_addr;
  logic [IMEM_DW-1:0] cpu_instr;
  logic               cpu_valid;
  logic               cpu_hold;
  logic               ld_valid;
  logic [IMEM_DW-1:0] ld_addr;
  logic [IMEM_DW-1:0] ld_data;
  logic               ld_ready;
  logic               ld_done;
  logic               ld_start;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic [IMEM_DW-1:0] mem_wdata;
  logic [IMEM_DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, ld_valid, ld_addr, ld_data, ld_done, ld_start, mem_rdata,
    output cpu_instr, cpu_valid, cpu_hold, ld_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, ld_valid, ld_addr, ld_data, ld_done, ld_start, mem_rdata,
    input  cpu_instr, cpu_valid, cpu_hold, ld_ready, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_starve_ctr.sv
// Saturating count of cycles a pending loader write has been refused;
// at_max tells the arbiter the loader must win this cycle.
module imem_starve_ctr #(
  parameter int MAX = 15,
  parameter int W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_r;

  // Counter register: clear has priority over increment, holds at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != MAX_V)) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_V);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between CPU fetch and the boot loader.
// Optional IMEM_CHECKSUM_EN adds a running sum of accepted loader data.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int AW         = IMEM_AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  imem_arbiter_if.slave      bus,
`ifdef IMEM_CHECKSUM_EN
  output logic [IMEM_DW-1:0] ld_checksum,
`endif
  output logic               state
);

  imem_state_e state_r;
  imem_state_e state_nx_s;
  logic        cpu_hold_r;
  logic        cpu_valid_r;
  logic        cpu_grant_s;
  logic        ld_grant_s;
  logic        at_max_s;
  logic        starve_inc_s;
  logic        starve_clr_s;
  logic        unused_s;

  // Next state and per-cycle grant decision.
  always_comb begin
    state_nx_s  = state_r;
    cpu_grant_s = 1'b0;
    ld_grant_s  = 1'b0;
    case (state_r)
      S_LOAD: begin
        ld_grant_s = bus.ld_valid;
        if (bus.ld_done) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_RUN: begin
        if (bus.ld_start) begin
          state_nx_s = S_LOAD;
        end else begin
          state_nx_s = S_RUN;
        end
        // A starved loader beats the CPU; a reload cycle never grants the CPU.
        if (bus.ld_valid && at_max_s) begin
          ld_grant_s = 1'b1;
        end else if (bus.cpu_req && !bus.ld_start) begin
          cpu_grant_s = 1'b1;
        end else if (bus.ld_valid) begin
          ld_grant_s = 1'b1;
        end else begin
          ld_grant_s  = 1'b0;
          cpu_grant_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = S_LOAD;
      end
    endcase
  end

  assign starve_inc_s = (state_r == S_RUN) && bus.ld_valid && !ld_grant_s;
  assign starve_clr_s = ld_grant_s || ((state_r == S_RUN) && bus.ld_start);

  imem_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (8)
  ) u_starve (
    .clk    (clk),
    .rst_n  (resetn),
    .clr    (starve_clr_s),
    .inc    (starve_inc_s),
    .at_max (at_max_s)
  );

  // State, CPU hold and read-valid registers; hold tracks the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_LOAD;
      cpu_hold_r  <= 1'b1;
      cpu_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cpu_hold_r  <= (state_nx_s == S_LOAD);
      cpu_valid_r <= cpu_grant_s;
    end
  end

  // Reset gates the write strobe so nothing reaches the RAM while held.
  assign bus.ld_ready  = ld_grant_s & resetn;
  assign bus.mem_we    = ld_grant_s & resetn;
  assign bus.mem_addr  = cpu_grant_s ? bus.cpu_addr[AW-1:0] : bus.ld_addr[AW-1:0];
  assign bus.mem_wdata = bus.ld_data;
  assign bus.cpu_instr = bus.mem_rdata;
  assign bus.cpu_valid = cpu_valid_r;
  assign bus.cpu_hold  = cpu_hold_r;
  assign state         = state_r;

  assign unused_s = ^{bus.cpu_addr[IMEM_DW-1:AW], bus.ld_addr[IMEM_DW-1:AW]};

`ifdef IMEM_CHECKSUM_EN
  logic [IMEM_DW-1:0] cksum_r;

  // Running sum of accepted loader data, restarted when a reload begins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cksum_r <= {IMEM_DW{1'b0}};
    end else if ((state_r == S_RUN) && bus.ld_start) begin
      cksum_r <= {IMEM_DW{1'b0}};
    end else if (ld_grant_s) begin
      cksum_r <= cksum_r + bus.ld_data;
    end else begin
      cksum_r <= cksum_r;
    end
  end

  assign ld_checksum = cksum_r;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: fetch results are checked by a scoreboard
// queue fed by the stimulus and drained by a monitor on cpu_valid.
module tb_imem_arbiter;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        state;
`ifdef IMEM_CHECKSUM_EN
  logic [15:0] ld_checksum;
`endif
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ram [256];

  imem_arbiter_if #(.AW(8)) bus ();

  imem_arbiter #(.AW(8), .STARVE_MAX(15)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
`ifdef IMEM_CHECKSUM_EN
    .ld_checksum (ld_checksum),
`endif
    .state       (state)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented instruction must match the oldest expectation.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && bus.cpu_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cpu_valid actual=%h required=none", bus.cpu_instr);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_instr", {16'h0000, bus.cpu_instr}, {16'h0000, e});
        end
      end
    end
  end

  task automatic ld_write(input logic [15:0] a, input logic [15:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(negedge clk);
    chk("ld_ready", bus.ld_ready, 1'b1);
    chk("mem_we", bus.mem_we, 1'b1);
    chk("ld_mem_addr", bus.mem_addr, a[7:0]);
    chk("mem_wdata", bus.mem_wdata, d);
    step();
    bus.ld_valid = 1'b0;
  endtask

  task automatic enter_run(input logic with_start);
    bus.ld_done  = 1'b1;
    bus.ld_start = with_start;
    @(negedge clk);
    chk("hold_before_done", bus.cpu_hold, 1'b1);
    step();
    bus.ld_done  = 1'b0;
    bus.ld_start = 1'b0;
    chk("state_run", state, 1'b1);
    chk("hold_released", bus.cpu_hold, 1'b0);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    chk("fetch_no_we", bus.mem_we, 1'b0);
    chk("fetch_mem_addr", bus.mem_addr, a[7:0]);
    exp_q.push_back(d);
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("fetch_latency", bus.cpu_valid, 1'b1);
    step();
  endtask

  initial begin
    resetn       = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 16'h0000;
    bus.ld_data  = 16'h0000;
    bus.ld_done  = 1'b0;
    bus.ld_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 1'b0);
    chk("rst_hold", bus.cpu_hold, 1'b1);
    chk("rst_valid", bus.cpu_valid, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_ready", bus.ld_ready, 1'b0);
    bus.ld_valid = 1'b0;
    resetn       = 1'b1;
    step();

    // Load phase; CPU requests during LOAD must never produce cpu_valid.
    bus.cpu_req = 1'b1;
    ld_write(16'h0000, 16'h0010);
    ld_write(16'h0001, 16'h0020);
    bus.cpu_req = 1'b0;
    ld_write(16'h0105, 16'hBEEF);
    enter_run(1'b0);
    fetch(16'h0001, 16'h0020);
    fetch(16'h0005, 16'hBEEF);
    fetch(16'h0100, 16'h0010);

    // Idle-bus loader write in RUN, then immediate read-back.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 16'h0020;
    bus.ld_data  = 16'h5A5A;
    @(negedge clk);
    chk("run_ld_ready", bus.ld_ready, 1'b1);
    step();
    bus.ld_valid = 1'b0;
    fetch(16'h0020, 16'h5A5A);

    // Starvation: two consecutive rounds of 15 refusals then one grant.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0001;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 16'h0010;
    bus.ld_data  = 16'h1234;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 15 || i == 31) begin
        chk("starve_grant", bus.ld_ready, 1'b1);
        chk("starve_we", bus.mem_we, 1'b1);
      end else begin
        chk("starve_refuse", bus.ld_ready, 1'b0);
        exp_q.push_back(16'h0020);
      end
      if (i == 16) chk("valid_after_ld_grant", bus.cpu_valid, 1'b0);
      step();
    end
    bus.cpu_req  = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("valid_after_ld_grant2", bus.cpu_valid, 1'b0);
    step();
    fetch(16'h0010, 16'h1234);

    // Reload with ld_done also high; CPU requests ignored until done.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0001;
    bus.ld_start = 1'b1;
    bus.ld_done  = 1'b1;
    @(negedge clk);
    chk("reload_no_we", bus.mem_we, 1'b0);
    step();
    bus.ld_start = 1'b0;
    bus.ld_done  = 1'b0;
    chk("reload_state", state, 1'b0);
    chk("reload_hold", bus.cpu_hold, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    chk("cksum_cleared", ld_checksum, 16'h0000);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("reload_no_valid", bus.cpu_valid, 1'b0);
      step();
    end
    bus.cpu_req = 1'b0;
    ld_write(16'h0030, 16'hFFFF);
    ld_write(16'h0031, 16'h0002);
`ifdef IMEM_CHECKSUM_EN
    chk("cksum_sum", ld_checksum, 16'h0001);
`endif
    enter_run(1'b1);
`ifdef IMEM_CHECKSUM_EN
    chk("cksum_start_in_load", ld_checksum, 16'h0001);
`endif
    fetch(16'h0031, 16'h0002);

    // Async reset while a read result is in flight.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0005;
    step();
    chk("inflight_valid", bus.cpu_valid, 1'b1);
    #1;
    resetn       = 1'b0;
    bus.ld_valid = 1'b1;
    #1;
    chk("async_hold", bus.cpu_hold, 1'b1);
    chk("async_valid", bus.cpu_valid, 1'b0);
    chk("async_we", bus.mem_we, 1'b0);
    chk("async_ready", bus.ld_ready, 1'b0);
    chk("async_state", state, 1'b0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    resetn       = 1'b1;
    step();
    enter_run(1'b0);
    fetch(16'h0005, 16'hBEEF);
    fetch(16'h0105, 16'hBEEF);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
